// File: rtl/ns_stats_sampler.sv
// Periodic sampler for a bank of packet counters: captures all counters on a
// programmable interval, computes deltas and streams one record per interval.
module ns_stats_sampler #(
    parameter int          N_CH  = 4,
    parameter logic [15:0] MAGIC = 16'hC0DE
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic [31:0]          interval,
    input  logic [32*N_CH-1:0]   ch_len4160,
    input  logic [32*N_CH-1:0]   ch_bad,
    input  logic [32*N_CH-1:0]   ch_other,
    output logic [31:0]          axis_out_tdata,
    output logic                 axis_out_tvalid,
    input  logic                 axis_out_tready,
    output logic                 axis_out_tlast,
    output logic                 busy,
    output logic [15:0]          seq_num,
    output logic [31:0]          overruns
);

    localparam int NW    = 3 * N_CH;
    localparam int RLEN  = NW + 1;
    localparam int IDX_W = $clog2(RLEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [15:0]        seq_q, seq_d;
    logic [15:0]        seq_num_q, seq_num_d;
    logic [31:0]        ovr_q, ovr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               busy_q, busy_d;
    logic [31:0]        base_q  [NW];
    logic [31:0]        base_d  [NW];
    logic [31:0]        delta_q [NW];
    logic [31:0]        delta_d [NW];

    logic [31:0]        live_s [NW];
    logic [31:0]        reload_s;
    logic [31:0]        timer_tick_s;
    logic [31:0]        ovr_inc_s;
    logic               expire_s;

    // Flatten the live counters into record order: per channel len, bad, other.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            live_s[3*k]     = ch_len4160[32*k +: 32];
            live_s[3*k + 1] = ch_bad[32*k +: 32];
            live_s[3*k + 2] = ch_other[32*k +: 32];
        end
    end

    // An interval of zero behaves like one: the timer reloads to zero every cycle.
    assign reload_s     = (interval == 32'd0) ? 32'd0 : (interval - 32'd1);
    assign expire_s     = (timer_q == 32'd0);
    assign timer_tick_s = expire_s ? reload_s : (timer_q - 32'd1);
    assign ovr_inc_s    = (ovr_q == 32'hFFFF_FFFF) ? ovr_q : (ovr_q + 32'd1);

    // Next-state, timer, capture and stream word sequencing.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        seq_d     = seq_q;
        seq_num_d = seq_num_q;
        ovr_d     = ovr_q;
        idx_d     = idx_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        base_d    = base_q;
        delta_d   = delta_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                base_d  = live_s;
                timer_d = reload_s;
                seq_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (expire_s) begin
                    timer_d = reload_s;
                    state_d = S_CAPTURE;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_CAPTURE: begin
                timer_d = timer_tick_s;
                if (expire_s) begin
                    ovr_d = ovr_inc_s;
                end else begin
                    ovr_d = ovr_q;
                end
                for (int i = 0; i < NW; i++) begin
                    delta_d[i] = live_s[i] - base_q[i];
                end
                base_d    = live_s;
                seq_num_d = seq_q;
                seq_d     = seq_q + 16'd1;
                tdata_d   = {MAGIC, seq_q};
                tvalid_d  = 1'b1;
                tlast_d   = 1'b0;
                idx_d     = {IDX_W{1'b0}};
                state_d   = S_SEND;
            end
            S_SEND: begin
                // The timer keeps running; an expiry here drops that capture.
                timer_d = timer_tick_s;
                if (expire_s) begin
                    ovr_d = ovr_inc_s;
                end else begin
                    ovr_d = ovr_q;
                end
                if (tvalid_q && axis_out_tready) begin
                    if (idx_q == IDX_W'(RLEN - 1)) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = enable ? S_WAIT : S_IDLE;
                    end else begin
                        idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        tdata_d = delta_q[idx_q];
                        tlast_d = (idx_q == IDX_W'(RLEN - 2));
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset clears everything including the stream.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            timer_q   <= 32'd0;
            seq_q     <= 16'd0;
            seq_num_q <= 16'd0;
            ovr_q     <= 32'd0;
            idx_q     <= {IDX_W{1'b0}};
            tdata_q   <= 32'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                base_q[i]  <= 32'd0;
                delta_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_q     <= seq_d;
            seq_num_q <= seq_num_d;
            ovr_q     <= ovr_d;
            idx_q     <= idx_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= busy_d;
            base_q    <= base_d;
            delta_q   <= delta_d;
        end
    end

    assign axis_out_tdata  = tdata_q;
    assign axis_out_tvalid = tvalid_q;
    assign axis_out_tlast  = tlast_q;
    assign busy            = busy_q;
    assign seq_num         = seq_num_q;
    assign overruns        = ovr_q;

endmodule

// File: tb/tb_ns_stats_sampler.sv
// Directed bench for ns_stats_sampler (N_CH=2) with an expected-word queue
// filled by the stimulus and drained by a stream monitor.
module tb_ns_stats_sampler;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic [31:0] interval;
    logic [63:0] ch_len4160;
    logic [63:0] ch_bad;
    logic [63:0] ch_other;
    logic [31:0] axis_out_tdata;
    logic        axis_out_tvalid;
    logic        axis_out_tready;
    logic        axis_out_tlast;
    logic        busy;
    logic [15:0] seq_num;
    logic [31:0] overruns;

    logic [31:0] len0;
    logic [31:0] bad1;
    logic        inc_len0;

    int          checks = 0;
    int          errors = 0;
    int          rec_done = 0;
    int          word_cnt = 0;
    int          cyc = 0;
    int          prev_hdr = -1;
    logic        spacing_on = 1'b0;
    logic [32:0] exp_q[$];

    assign ch_len4160 = {32'd5, len0};
    assign ch_bad     = {bad1, 32'd5};
    assign ch_other   = {32'd5, 32'd5};

    ns_stats_sampler #(.N_CH(2), .MAGIC(16'hC0DE)) dut (
        .clk             (clk),
        .areset          (areset),
        .enable          (enable),
        .interval        (interval),
        .ch_len4160      (ch_len4160),
        .ch_bad          (ch_bad),
        .ch_other        (ch_other),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tlast  (axis_out_tlast),
        .busy            (busy),
        .seq_num         (seq_num),
        .overruns        (overruns)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (inc_len0) len0 = len0 + 32'd1;
    endtask

    // Record with only ch0 len and ch1 bad deltas possibly non-zero.
    task automatic push_rec(input logic [15:0] seq, input logic [31:0] dlen0, input logic [31:0] dbad1);
        exp_q.push_back({1'b0, 16'hC0DE, seq});
        exp_q.push_back({1'b0, dlen0});
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, dbad1});
        exp_q.push_back({1'b1, 32'd0});
    endtask

    task automatic wait_recs(input int n);
        int target = rec_done + n;
        int budget = 2000;
        while (rec_done < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("record_count", rec_done, target);
    endtask

    task automatic wait_words(input int n);
        int budget = 2000;
        while (word_cnt < n && budget > 0) begin
            tick();
            budget--;
        end
        chk("word_reached", word_cnt, n);
    endtask

    task automatic monitor();
        logic [32:0] w;
        forever begin
            @(negedge clk);
            cyc++;
            if (!areset && axis_out_tvalid && axis_out_tready) begin
                if (word_cnt == 0 && spacing_on) begin
                    if (prev_hdr >= 0) chk("hdr_spacing", cyc - prev_hdr, 32'd100);
                    prev_hdr = cyc;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_word observed=%h expected=none", axis_out_tdata);
                end else begin
                    w = exp_q.pop_front();
                    chk("tdata", axis_out_tdata, w[31:0]);
                    chk("tlast", {31'd0, axis_out_tlast}, {31'd0, w[32]});
                end
                if (axis_out_tlast) begin
                    word_cnt = 0;
                    rec_done++;
                end else begin
                    word_cnt++;
                end
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        enable = 1'b0;
        interval = 32'd100;
        axis_out_tready = 1'b1;
        len0 = 32'd5;
        bad1 = 32'd5;
        inc_len0 = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_tdata", axis_out_tdata, 32'd0);
        chk("rst_tvalid", {31'd0, axis_out_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, axis_out_tlast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_seq_num", {16'd0, seq_num}, 32'd0);
        chk("rst_overruns", overruns, 32'd0);
        areset = 1'b0;
        tick();

        // Static counters, interval 100: zero deltas, seq 0,1,2, 100 cycles apart
        spacing_on = 1'b1;
        push_rec(16'd0, 32'd0, 32'd0);
        push_rec(16'd1, 32'd0, 32'd0);
        push_rec(16'd2, 32'd0, 32'd0);
        enable = 1'b1;
        tick();
        chk("busy_armed", {31'd0, busy}, 32'd1);
        wait_recs(3);
        chk("seq_num_t1", {16'd0, seq_num}, 32'd2);
        enable = 1'b0;
        spacing_on = 1'b0;
        repeat (3) tick();
        chk("idle_after_wait", {31'd0, busy}, 32'd0);

        // Incrementing len0 with interval 50, plus a wrapping bad1 counter
        interval = 32'd50;
        inc_len0 = 1'b1;
        bad1 = 32'hFFFF_FFF0;
        push_rec(16'd0, 32'd51, 32'd0);
        push_rec(16'd1, 32'd50, 32'd0);
        enable = 1'b1;
        wait_recs(2);
        bad1 = bad1 + 32'd32;
        push_rec(16'd2, 32'd50, 32'd32);
        wait_recs(1);
        enable = 1'b0;
        repeat (3) tick();

        // Back-pressure across two expiries: two overruns, triple-length deltas
        push_rec(16'd0, 32'd51, 32'd0);
        enable = 1'b1;
        wait_recs(1);
        repeat (40) tick();
        axis_out_tready = 1'b0;
        push_rec(16'd1, 32'd50, 32'd0);
        for (int i = 0; i < 120; i++) begin
            tick();
            if (axis_out_tvalid) begin
                chk("stall_tdata", axis_out_tdata, 32'hC0DE_0001);
                chk("stall_tlast", {31'd0, axis_out_tlast}, 32'd0);
            end
        end
        chk("stall_tvalid", {31'd0, axis_out_tvalid}, 32'd1);
        chk("overruns_stall", overruns, 32'd2);
        chk("seq_num_stall", {16'd0, seq_num}, 32'd1);
        axis_out_tready = 1'b1;
        push_rec(16'd2, 32'd150, 32'd0);
        wait_recs(2);
        chk("seq_num_after_stall", {16'd0, seq_num}, 32'd2);
        chk("overruns_hold", overruns, 32'd2);

        // Drop enable mid-record: record completes, then idle; re-enable restarts seq
        push_rec(16'd3, 32'd50, 32'd0);
        wait_words(3);
        enable = 1'b0;
        wait_recs(1);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("tvalid_fall", {31'd0, axis_out_tvalid}, 32'd0);
        repeat (5) tick();
        chk("busy_stays_low", {31'd0, busy}, 32'd0);
        push_rec(16'd0, 32'd51, 32'd0);
        enable = 1'b1;
        wait_recs(1);
        chk("seq_num_reenable", {16'd0, seq_num}, 32'd0);

        // Asynchronous reset in the middle of a record
        push_rec(16'd1, 32'd50, 32'd0);
        wait_words(2);
        areset = 1'b1;
        #1;
        chk("arst_tvalid", {31'd0, axis_out_tvalid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_seq_num", {16'd0, seq_num}, 32'd0);
        chk("arst_overruns", overruns, 32'd0);
        exp_q.delete();
        word_cnt = 0;
        tick();
        push_rec(16'd0, 32'd51, 32'd0);
        areset = 1'b0;
        wait_recs(1);
        chk("post_rst_seq_num", {16'd0, seq_num}, 32'd0);
        chk("post_rst_overruns", overruns, 32'd0);
        enable = 1'b0;
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
